pir_input_conditioner: RTL and testbench

Front-end conditioning stage directly upstream of the PIR motion controller. Accepts raw 7-bit samples from three PIR sensors through a valid/ready handshake. Clamps each sample, removes single-sample spikes with a per-channel median-of-3 filter, and flags stuck sensors. Presents stable registered values on `pir_sensor_1..3` for the controller's averaging logic.

---
 rtl/pir_input_conditioner_pkg.sv | 25 ++
 rtl/pir_input_conditioner_if.sv | 28 ++
 rtl/pir_input_conditioner_median3.sv | 20 ++
 rtl/pir_input_conditioner.sv | 139 +++++++++++++
 tb/tb_pir_input_conditioner.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pir_input_conditioner_pkg.sv
// Shared types and constants for the PIR input conditioner.
// One-hot FSM encoding, sample width and channel count live here.
package pir_pkg;

  localparam int unsigned PIR_W   = 7;
  localparam int unsigned PIR_CH  = 3;
  localparam int unsigned STUCK_W = 8;

  typedef logic [PIR_W-1:0] pir_sample_t;

  typedef struct packed {
    pir_sample_t raw_3;
    pir_sample_t raw_2;
    pir_sample_t raw_1;
  } pir_triple_t;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_CH1    = 5'b00010,
    ST_CH2    = 5'b00100,
    ST_CH3    = 5'b01000,
    ST_COMMIT = 5'b10000
  } pir_state_e;

endpackage

// File: rtl/pir_input_conditioner_if.sv
// Sample handshake and conditioned-output bundle of the PIR input conditioner.
interface pir_input_conditioner_if;
  import pir_pkg::*;

  logic                sample_valid;
  pir_sample_t         raw_1;
  pir_sample_t         raw_2;
  pir_sample_t         raw_3;
  logic                sample_ready;
  pir_sample_t         pir_sensor_1;
  pir_sample_t         pir_sensor_2;
  pir_sample_t         pir_sensor_3;
  logic                out_valid;
  logic [PIR_CH-1:0]   sensor_fault;

  modport master (
    output sample_valid, raw_1, raw_2, raw_3,
    input  sample_ready, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    input  out_valid, sensor_fault
  );

  modport slave (
    input  sample_valid, raw_1, raw_2, raw_3,
    output sample_ready, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    output out_valid, sensor_fault
  );

endinterface

// File: rtl/pir_input_conditioner_median3.sv
// Combinational median of three unsigned samples.
module pir_median3
  import pir_pkg::*;
(
  input  pir_sample_t a,
  input  pir_sample_t b,
  input  pir_sample_t c,
  output pir_sample_t med_c
);

  pir_sample_t lo;
  pir_sample_t hi;

  always_comb begin
    lo    = (a < b) ? a : b;
    hi    = (a < b) ? b : a;
    med_c = (c < lo) ? lo : ((c > hi) ? hi : c);
  end

endmodule

// File: rtl/pir_input_conditioner.sv
// Clamp, median-of-3 de-spike and stuck detection for three PIR channels.
// Define PIR_COND_MEDIAN_EN to compile in the median filter; otherwise it is bypassed.
module pir_input_conditioner
  import pir_pkg::*;
#(
  parameter int unsigned SAT_MAX     = 100,
  parameter int unsigned STUCK_LIMIT = 64
) (
  input logic clk,
  input logic rst,
  pir_input_conditioner_if.slave bus
);

  localparam pir_sample_t         SAT_C   = PIR_W'(SAT_MAX);
  localparam logic [STUCK_W-1:0]  LIMIT_C = STUCK_W'(STUCK_LIMIT);

  pir_state_e state, state_nxt;
  logic       proc_c;
  logic [1:0] ch_sel_c;
  logic       accept_c;

  pir_triple_t        cap;
  pir_sample_t        h0    [PIR_CH];
  logic [1:0]         cnt   [PIR_CH];
  logic [STUCK_W-1:0] stuck [PIR_CH];
  pir_sample_t        filt  [PIR_CH];
  logic [PIR_CH-1:0]  fault_r;

  pir_sample_t        raw_sel_c;
  pir_sample_t        c_c;
  pir_sample_t        f_c;
  logic               same_c;
  logic [STUCK_W-1:0] stuck_nxt_c;
  logic               fault_nxt_c;

  assign bus.sample_ready = (state == ST_IDLE);
  assign accept_c         = bus.sample_ready && bus.sample_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus which channel the shared datapath serves this cycle
  always_comb begin
    state_nxt = state;
    proc_c    = 1'b0;
    ch_sel_c  = 2'd0;
    case (state)
      ST_IDLE:   if (accept_c) state_nxt = ST_CH1;
      ST_CH1:    begin proc_c = 1'b1; ch_sel_c = 2'd0; state_nxt = ST_CH2;    end
      ST_CH2:    begin proc_c = 1'b1; ch_sel_c = 2'd1; state_nxt = ST_CH3;    end
      ST_CH3:    begin proc_c = 1'b1; ch_sel_c = 2'd2; state_nxt = ST_COMMIT; end
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (ch_sel_c)
      2'd1:    raw_sel_c = cap.raw_2;
      2'd2:    raw_sel_c = cap.raw_3;
      default: raw_sel_c = cap.raw_1;
    endcase
  end

  assign c_c = (raw_sel_c > SAT_C) ? SAT_C : raw_sel_c;

`ifdef PIR_COND_MEDIAN_EN
  pir_sample_t h1 [PIR_CH];
  pir_sample_t med_c;

  pir_median3 u_median3 (
    .a     (h0[ch_sel_c]),
    .b     (h1[ch_sel_c]),
    .c     (c_c),
    .med_c (med_c)
  );

  assign f_c = (cnt[ch_sel_c] == 2'd2) ? med_c : c_c;
`else
  assign f_c = c_c;
`endif

  // Stuck counter saturates so the fault holds for as long as the value repeats
  always_comb begin
    same_c      = (cnt[ch_sel_c] != 2'd0) && (c_c == h0[ch_sel_c]);
    stuck_nxt_c = '0;
    if (same_c)
      stuck_nxt_c = (stuck[ch_sel_c] == LIMIT_C) ? LIMIT_C : stuck[ch_sel_c] + STUCK_W'(1);
    fault_nxt_c = (stuck_nxt_c == LIMIT_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap     <= '0;
      fault_r <= '0;
      for (int unsigned i = 0; i < PIR_CH; i++) begin
        h0[i]    <= '0;
`ifdef PIR_COND_MEDIAN_EN
        h1[i]    <= '0;
`endif
        cnt[i]   <= '0;
        stuck[i] <= '0;
        filt[i]  <= '0;
      end
      bus.pir_sensor_1 <= '0;
      bus.pir_sensor_2 <= '0;
      bus.pir_sensor_3 <= '0;
      bus.sensor_fault <= '0;
      bus.out_valid    <= 1'b0;
    end else begin
      if (accept_c) begin
        cap.raw_1 <= bus.raw_1;
        cap.raw_2 <= bus.raw_2;
        cap.raw_3 <= bus.raw_3;
      end
      if (proc_c) begin
`ifdef PIR_COND_MEDIAN_EN
        h1[ch_sel_c]    <= h0[ch_sel_c];
`endif
        h0[ch_sel_c]    <= c_c;
        cnt[ch_sel_c]   <= (cnt[ch_sel_c] == 2'd2) ? 2'd2 : cnt[ch_sel_c] + 2'd1;
        stuck[ch_sel_c] <= stuck_nxt_c;
        fault_r[ch_sel_c] <= fault_nxt_c;
        // A stuck channel reads as zero so it can never hold the controller in alarm
        filt[ch_sel_c]  <= fault_nxt_c ? '0 : f_c;
      end
      bus.out_valid <= (state == ST_COMMIT);
      if (state == ST_COMMIT) begin
        bus.pir_sensor_1 <= filt[0];
        bus.pir_sensor_2 <= filt[1];
        bus.pir_sensor_3 <= filt[2];
        bus.sensor_fault <= fault_r;
      end
    end
  end

endmodule

// File: tb/tb_pir_input_conditioner.sv
// Directed self-checking bench for pir_input_conditioner; expected values hand-computed.
module tb_pir_input_conditioner;
  import pir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pir_input_conditioner_if bus ();

  pir_input_conditioner #(.SAT_MAX(100), .STUCK_LIMIT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef PIR_COND_MEDIAN_EN
  localparam bit MED = 1'b1;
`else
  localparam bit MED = 1'b0;
`endif

  logic [6:0] spike_in  [4] = '{7'd20, 7'd20, 7'd120, 7'd20};
  logic [6:0] spike_med [4] = '{7'd20, 7'd20, 7'd20,  7'd20};
  logic [6:0] spike_raw [4] = '{7'd20, 7'd20, 7'd100, 7'd20};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, 32'(bus.sample_ready), 1);
    check({tag, "_ovalid"}, 32'(bus.out_valid), 0);
    check({tag, "_s1"}, 32'(bus.pir_sensor_1), 0);
    check({tag, "_s2"}, 32'(bus.pir_sensor_2), 0);
    check({tag, "_s3"}, 32'(bus.pir_sensor_3), 0);
    check({tag, "_fault"}, 32'(bus.sensor_fault), 0);
  endtask

  // Offer one triple, scramble raw_* while it is processed, wait (bounded) for out_valid
  task automatic send(input logic [6:0] r1, input logic [6:0] r2, input logic [6:0] r3,
                      input bit pulse_ch2);
    int n;
    bit seen;
    @(negedge clk);
    check("ready_before_accept", 32'(bus.sample_ready), 1);
    bus.sample_valid = 1'b1;
    bus.raw_1 = r1;
    bus.raw_2 = r2;
    bus.raw_3 = r3;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.raw_1 = 7'h55;
    bus.raw_2 = 7'h2a;
    bus.raw_3 = 7'h7f;
    check("ready_low_busy", 32'(bus.sample_ready), 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (pulse_ch2 && n == 1) begin
        bus.sample_valid = 1'b1;
        bus.raw_1 = 7'd99;
        bus.raw_2 = 7'd99;
        bus.raw_3 = 7'd99;
      end
      if (n == 2) bus.sample_valid = 1'b0;
      seen = bus.out_valid;
    end
    check("out_valid_latency", 32'(n), 4);
  endtask

  task automatic expect_out(input string tag, input logic [6:0] e1, input logic [6:0] e2,
                            input logic [6:0] e3, input logic [2:0] ef);
    check({tag, "_s1"}, 32'(bus.pir_sensor_1), 32'(e1));
    check({tag, "_s2"}, 32'(bus.pir_sensor_2), 32'(e2));
    check({tag, "_s3"}, 32'(bus.pir_sensor_3), 32'(e3));
    check({tag, "_fault"}, 32'(bus.sensor_fault), 32'(ef));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc [3];
    int k;
    int ovs;
    int n;
    bit seen;

    bus.sample_valid = 1'b0;
    bus.raw_1 = '0;
    bus.raw_2 = '0;
    bus.raw_3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    // Pass-through for the first two triples, median on the third
    send(7'd10, 7'd20, 7'd30, 1'b0);
    expect_out("t1", 7'd10, 7'd20, 7'd30, 3'b000);
    send(7'd12, 7'd22, 7'd32, 1'b0);
    expect_out("t2", 7'd12, 7'd22, 7'd32, 3'b000);
    send(7'd14, 7'd24, 7'd34, 1'b0);
    if (MED) expect_out("t3", 7'd12, 7'd22, 7'd32, 3'b000);
    else     expect_out("t3", 7'd14, 7'd24, 7'd34, 3'b000);
    @(negedge clk);
    check("out_valid_one_cycle", 32'(bus.out_valid), 0);

    // Spike on channel 1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(spike_in[i], 7'd50, 7'd60, 1'b0);
      check($sformatf("spike_%0d", i), 32'(bus.pir_sensor_1),
            32'(MED ? spike_med[i] : spike_raw[i]));
    end

    // Clamp
    do_reset();
    send(7'd5, 7'd127, 7'd7, 1'b0);
    expect_out("clamp", 7'd5, 7'd100, 7'd7, 3'b000);

    // Stuck channel 3; channels 1/2 alternate so they never stick
    do_reset();
    for (int i = 1; i <= 65; i++) begin
      send(7'((i % 2) ? 10 : 11), 7'((i % 2) ? 40 : 41), 7'd60, 1'b0);
      if (i == 64) begin
        check("stuck64_fault", 32'(bus.sensor_fault), 0);
        check("stuck64_s3", 32'(bus.pir_sensor_3), 60);
      end
      if (i == 65) begin
        check("stuck65_fault", 32'(bus.sensor_fault), 32'(3'b100));
        check("stuck65_s3", 32'(bus.pir_sensor_3), 0);
      end
    end
    send(7'd10, 7'd40, 7'd61, 1'b0);
    check("unstuck_fault", 32'(bus.sensor_fault), 0);
    check("unstuck_s3", 32'(bus.pir_sensor_3), MED ? 60 : 61);

    // Back-to-back with sample_valid held high
    do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.raw_1 = 7'd1;
    bus.raw_2 = 7'd2;
    bus.raw_3 = 7'd3;
    k = 0;
    ovs = 0;
    for (int c = 0; c < 30 && k < 3; c++) begin
      if (bus.sample_ready) begin
        acc[k] = c;
        k++;
      end
      @(negedge clk);
      if (bus.out_valid) ovs++;
    end
    bus.sample_valid = 1'b0;
    check("b2b_count", 32'(k), 3);
    if (k == 3) begin
      check("b2b_gap1", 32'(acc[1] - acc[0]), 5);
      check("b2b_gap2", 32'(acc[2] - acc[1]), 5);
    end
    check("b2b_ovalids", 32'(ovs), 2);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      seen = bus.out_valid;
    end
    check("b2b_last_latency", 32'(n), 4);
    expect_out("b2b", 7'd1, 7'd2, 7'd3, 3'b000);

    // Valid pulse during CH2 must be ignored
    do_reset();
    send(7'd7, 7'd8, 7'd9, 1'b1);
    expect_out("ch2pulse", 7'd7, 7'd8, 7'd9, 3'b000);
    ovs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) ovs++;
    end
    check("ch2pulse_no_extra", 32'(ovs), 0);

    // Reset in CH2 discards the triple and clears history
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.raw_1 = 7'd40;
    bus.raw_2 = 7'd41;
    bus.raw_3 = 7'd42;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("rst_ch2");
    ovs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) ovs++;
    end
    check("rst_ch2_no_ovalid", 32'(ovs), 0);
    send(7'd70, 7'd71, 7'd72, 1'b0);
    expect_out("post_rst", 7'd70, 7'd71, 7'd72, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
